str_glyph_renderer: RTL

- Reader-side consumer of the combinational glyph-bitmap ROMs (32-bit row words, 64 rows per glyph, glyph-major addressing).
- Holds a short string of glyph codes and turns a streamed VGA pixel coordinate into the corresponding 1-bit glyph pixel.
- Drives the ROM address, registers the returned row word, and emits a pixel stream with fixed latency to the colour mixer.
- String updates are double-buffered and take effect only at frame boundaries, so a frame never shows a half-updated string.

---
 rtl/str_glyph_renderer_if.sv | 39 +++
 rtl/str_glyph_renderer.sv | 113 +++++++++++
 2 files changed

// File: rtl/str_glyph_renderer_if.sv
// Bus bundle between the string glyph renderer, its glyph ROM, the string writer and the pixel consumer.
interface str_glyph_renderer_if #(
    parameter int unsigned glyph_width_p  = 32,
    parameter int unsigned glyph_height_p = 64,
    parameter int unsigned num_glyphs_p   = 8,
    parameter int unsigned str_len_p      = 5,
    parameter int unsigned coord_width_p  = 10
);
    localparam int unsigned idx_w  = $clog2(str_len_p);
    localparam int unsigned code_w = $clog2(num_glyphs_p);
    localparam int unsigned addr_w = $clog2(num_glyphs_p * glyph_height_p);

    logic [coord_width_p-1:0] origin_x_i;
    logic [coord_width_p-1:0] origin_y_i;
    logic                     frame_start_i;
    logic                     str_v_i;
    logic                     str_ready_o;
    logic [idx_w-1:0]         str_idx_i;
    logic [code_w-1:0]        str_code_i;
    logic                     px_v_i;
    logic [coord_width_p-1:0] px_x_i;
    logic [coord_width_p-1:0] px_y_i;
    logic [addr_w-1:0]        rom_addr_o;
    logic [glyph_width_p-1:0] rom_data_i;
    logic                     pixel_v_o;
    logic                     pixel_o;

    modport slave (
        input  origin_x_i, origin_y_i, frame_start_i, str_v_i, str_idx_i, str_code_i,
        input  px_v_i, px_x_i, px_y_i, rom_data_i,
        output str_ready_o, rom_addr_o, pixel_v_o, pixel_o
    );

    modport master (
        output origin_x_i, origin_y_i, frame_start_i, str_v_i, str_idx_i, str_code_i,
        output px_v_i, px_x_i, px_y_i, rom_data_i,
        input  str_ready_o, rom_addr_o, pixel_v_o, pixel_o
    );
endinterface

// File: rtl/str_glyph_renderer.sv
// Renders a double-buffered glyph string into a 1-bit pixel stream: capture, ROM lookup, output.
module str_glyph_renderer #(
    parameter int unsigned glyph_width_p  = 32,
    parameter int unsigned glyph_height_p = 64,
    parameter int unsigned num_glyphs_p   = 8,
    parameter int unsigned str_len_p      = 5,
    parameter int unsigned coord_width_p  = 10
) (
    input logic clk_i,
    input logic reset_n_i,
    str_glyph_renderer_if.slave bus
);
    localparam int unsigned cw     = coord_width_p;
    localparam int unsigned idx_w  = $clog2(str_len_p);
    localparam int unsigned code_w = $clog2(num_glyphs_p);
    localparam int unsigned addr_w = $clog2(num_glyphs_p * glyph_height_p);
    localparam int unsigned col_w  = $clog2(glyph_width_p);
    localparam int unsigned row_w  = $clog2(glyph_height_p);
    localparam int unsigned box_w  = str_len_p * glyph_width_p;

    logic [code_w-1:0] shadow [str_len_p];
    logic [code_w-1:0] active [str_len_p];
    logic              dirty;

    logic              s0_v;
    logic              s0_in_box;
    logic [idx_w-1:0]  s0_slot;
    logic [col_w-1:0]  s0_col;
    logic [row_w-1:0]  s0_row;
    logic              s1_v;
    logic              s1_ink;
    logic              s1_bit;
    logic              pix_v_q;
    logic              pix_q;

    logic [cw:0]       dx;
    logic [cw:0]       dy;
    logic              in_box_c;
    logic [code_w-1:0] code_sel;
    logic [31:0]       addr_full;
    logic [col_w-1:0]  bit_idx;
    logic              ink_c;

    // Writes are refused only while the commit pulse is present.
    assign bus.str_ready_o = !bus.frame_start_i;
    assign bus.rom_addr_o  = s0_in_box ? addr_w'(addr_full) : '0;
    assign bus.pixel_v_o   = pix_v_q;
    assign bus.pixel_o     = pix_q;

    // Box test on an extra sign bit so coordinates left of / above the origin never wrap in.
    always_comb begin
        dx        = {1'b0, bus.px_x_i} - {1'b0, bus.origin_x_i};
        dy        = {1'b0, bus.px_y_i} - {1'b0, bus.origin_y_i};
        in_box_c  = !dx[cw] && (32'(dx[cw-1:0]) < box_w) &&
                    !dy[cw] && (32'(dy[cw-1:0]) < glyph_height_p);
        code_sel  = '0;
        for (int unsigned i = 0; i < str_len_p; i++) begin
            if (32'(s0_slot) == i) code_sel = active[i];
        end
        addr_full = 32'(code_sel) * glyph_height_p + 32'(s0_row);
        bit_idx   = col_w'(glyph_width_p - 1) - s0_col;
        ink_c     = s0_in_box && (32'(code_sel) < num_glyphs_p);
    end

    // Shadow/active string; commit copies the whole shadow at a frame boundary.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            dirty <= 1'b0;
            for (int unsigned i = 0; i < str_len_p; i++) begin
                shadow[i] <= code_w'((i < num_glyphs_p) ? i : num_glyphs_p - 1);
                active[i] <= code_w'((i < num_glyphs_p) ? i : num_glyphs_p - 1);
            end
        end else begin
            if (bus.frame_start_i && dirty) begin
                for (int unsigned i = 0; i < str_len_p; i++) active[i] <= shadow[i];
                dirty <= 1'b0;
            end
            if (bus.str_v_i && bus.str_ready_o && (32'(bus.str_idx_i) < str_len_p)) begin
                for (int unsigned i = 0; i < str_len_p; i++) begin
                    if (32'(bus.str_idx_i) == i) shadow[i] <= bus.str_code_i;
                end
                dirty <= 1'b1;
            end
        end
    end

    // Three register stages: coordinate capture, ROM bit select, pixel output.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            s0_v      <= 1'b0;
            s0_in_box <= 1'b0;
            s0_slot   <= '0;
            s0_col    <= '0;
            s0_row    <= '0;
            s1_v      <= 1'b0;
            s1_ink    <= 1'b0;
            s1_bit    <= 1'b0;
            pix_v_q   <= 1'b0;
            pix_q     <= 1'b0;
        end else begin
            s0_v      <= bus.px_v_i;
            s0_in_box <= bus.px_v_i && in_box_c;
            s0_slot   <= idx_w'(dx[cw-1:0] >> col_w);
            s0_col    <= dx[col_w-1:0];
            s0_row    <= dy[row_w-1:0];
            s1_v      <= s0_v;
            s1_ink    <= ink_c;
            s1_bit    <= bus.rom_data_i[bit_idx];
            pix_v_q   <= s1_v;
            pix_q     <= s1_v && s1_ink && s1_bit;
        end
    end
endmodule
